// File: rtl/ws281x_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ws281x_ctrl: reads pixel words from RAM, serialises 24 colour bits each   |
// | MSB-first to a WS281x bit encoder.                     Revision: 1.0     |
// +--------------------------------------------------------------------------+
module ws281x_ctrl (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        bit_done_in,
  input  logic        wr_done_in,
  input  logic [31:0] rd_data_in,
  input  logic [7:0]  tim_sum_in,
  output logic        bit_rdy_out,
  output logic        bit_data_out,
  output logic        rd_en_out,
  output logic [5:0]  rd_addr_out
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    READ = 3'd1,
    LOAD = 3'd2,
    SEND = 3'd3,
    WAIT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [6:0]  num_q, num_d;
  logic [5:0]  pix_q, pix_d;
  logic [4:0]  bcnt_q, bcnt_d;
  logic [23:0] shift_q, shift_d;
  logic        pend_q, pend_d;
  logic        bit_rdy_q, bit_rdy_d;
  logic        bit_data_q, bit_data_d;
  logic        rd_en_q, rd_en_d;
  logic [5:0]  rd_addr_q, rd_addr_d;

  logic [6:0]  tim_clip;
  logic [6:0]  pix_next;
  logic        unused_top;

  assign tim_clip   = (tim_sum_in > 8'd64) ? 7'd64 : tim_sum_in[6:0];
  assign pix_next   = {1'b0, pix_q} + 7'd1;
  assign unused_top = ^rd_data_in[31:24];

  always_comb begin
    state_d    = state_q;
    num_d      = num_q;
    pix_d      = pix_q;
    bcnt_d     = bcnt_q;
    shift_d    = shift_q;
    pend_d     = pend_q | (wr_done_in && (state_q != IDLE));
    bit_rdy_d  = 1'b0;
    bit_data_d = bit_data_q;
    rd_en_d    = 1'b0;
    rd_addr_d  = rd_addr_q;

    case (state_q)
      IDLE: begin
        if (wr_done_in) begin
          num_d = tim_clip;
          if (tim_clip != 7'd0) begin
            pix_d     = 6'd0;
            rd_en_d   = 1'b1;
            rd_addr_d = 6'd0;
            state_d   = READ;
          end
        end
      end
      READ: state_d = LOAD;
      LOAD: begin
        shift_d    = rd_data_in[23:0];
        bcnt_d     = 5'd23;
        bit_data_d = rd_data_in[23];
        bit_rdy_d  = 1'b1;
        state_d    = SEND;
      end
      SEND: state_d = WAIT;
      WAIT: begin
        if (bit_done_in) begin
          if (bcnt_q != 5'd0) begin
            shift_d    = {shift_q[22:0], 1'b0};
            bcnt_d     = bcnt_q - 5'd1;
            bit_data_d = shift_q[22];
            bit_rdy_d  = 1'b1;
            state_d    = SEND;
          end else if (pix_next < num_q) begin
            pix_d     = pix_next[5:0];
            rd_en_d   = 1'b1;
            rd_addr_d = pix_next[5:0];
            state_d   = READ;
          end else begin
            bit_data_d = 1'b0;
            state_d    = IDLE;
            // A write seen during the frame (or on this very edge) replays it.
            if (pend_q || wr_done_in) begin
              pend_d = 1'b0;
              num_d  = tim_clip;
              if (tim_clip != 7'd0) begin
                pix_d     = 6'd0;
                rd_en_d   = 1'b1;
                rd_addr_d = 6'd0;
                state_d   = READ;
              end
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      num_q      <= 7'd0;
      pix_q      <= 6'd0;
      bcnt_q     <= 5'd0;
      shift_q    <= 24'd0;
      pend_q     <= 1'b0;
      bit_rdy_q  <= 1'b0;
      bit_data_q <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= 6'd0;
    end else begin
      state_q    <= state_d;
      num_q      <= num_d;
      pix_q      <= pix_d;
      bcnt_q     <= bcnt_d;
      shift_q    <= shift_d;
      pend_q     <= pend_d;
      bit_rdy_q  <= bit_rdy_d;
      bit_data_q <= bit_data_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  assign bit_rdy_out  = bit_rdy_q;
  assign bit_data_out = bit_data_q;
  assign rd_en_out    = rd_en_q;
  assign rd_addr_out  = rd_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_ws281x_ctrl.sv
`default_nettype none
// Directed bench for ws281x_ctrl: table of frames plus hand-written latency,
// reset, restart and per-address sequences, with a pixel RAM and encoder model.
module tb_ws281x_ctrl;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        bit_done_in;
  logic        wr_done_in;
  logic [31:0] rd_data_in;
  logic [7:0]  tim_sum_in;
  logic        bit_rdy_out;
  logic        bit_data_out;
  logic        rd_en_out;
  logic [5:0]  rd_addr_out;

  ws281x_ctrl dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .bit_done_in  (bit_done_in),
    .wr_done_in   (wr_done_in),
    .rd_data_in   (rd_data_in),
    .tim_sum_in   (tim_sum_in),
    .bit_rdy_out  (bit_rdy_out),
    .bit_data_out (bit_data_out),
    .rd_en_out    (rd_en_out),
    .rd_addr_out  (rd_addr_out)
  );

  always #5 clk_in = ~clk_in;

  // Synchronous pixel RAM: data valid the cycle after the read enable.
  logic [31:0] mem [64];
  always @(posedge clk_in) if (rd_en_out) rd_data_in <= mem[rd_addr_out];

  typedef struct {
    logic [7:0]  tim;
    logic [31:0] word;
    int          exp_pix;
    logic [23:0] exp_bits;
  } vec_t;

  vec_t vecs [7];

  int   total = 0;
  int   bad   = 0;
  int   rdy_cnt, rden_cnt, glitch_err, stable_err, done_dly;
  logic bits_q [$];
  int   addr_q [$];
  int   exp_addr_q [$];
  logic [23:0] exp_data_q [$];
  logic prev_rdy, prev_rden, cur_bit, waiting, enc_en;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // One clock: sample outputs after the edge, then drive inputs for the next edge.
  task automatic step();
    @(posedge clk_in);
    #1;
    if (bit_rdy_out) begin
      bits_q.push_back(bit_data_out);
      rdy_cnt++;
      cur_bit = bit_data_out;
      waiting = 1'b1;
      if (prev_rdy) glitch_err++;
      if (enc_en) done_dly = 3;
    end else if (waiting && (bit_data_out !== cur_bit)) begin
      stable_err++;
    end
    if (rd_en_out) begin
      addr_q.push_back(int'(rd_addr_out));
      rden_cnt++;
      if (prev_rden) glitch_err++;
    end
    prev_rdy    = bit_rdy_out;
    prev_rden   = rd_en_out;
    bit_done_in = 1'b0;
    wr_done_in  = 1'b0;
    if (done_dly > 0) begin
      done_dly--;
      if (done_dly == 0) begin
        bit_done_in = 1'b1;
        waiting     = 1'b0;
      end
    end
  endtask

  task automatic clear_logs();
    bits_q.delete();
    addr_q.delete();
    exp_addr_q.delete();
    exp_data_q.delete();
    rdy_cnt = 0; rden_cnt = 0; glitch_err = 0; stable_err = 0;
    done_dly = 0; waiting = 1'b0; prev_rdy = 1'b0; prev_rden = 1'b0;
  endtask

  task automatic wait_frame(input int nbits, input string tag);
    int n;
    n = 0;
    while (!(rdy_cnt >= nbits && done_dly == 0 && !bit_done_in) && n < 12000) begin
      step();
      n++;
    end
    if (n >= 12000) begin
      total++;
      bad++;
      $display("FAIL %s.timeout: bits=%0d want %0d", tag, rdy_cnt, nbits);
    end
    repeat (10) step();
  endtask

  task automatic check_frame(input string tag);
    int n, m;
    logic [23:0] got;
    n = exp_addr_q.size();
    check({tag, ".rd_en_count"}, rden_cnt, n);
    check({tag, ".bit_count"}, rdy_cnt, n * 24);
    check({tag, ".pulse_width"}, glitch_err, 0);
    check({tag, ".bit_stable"}, stable_err, 0);
    check({tag, ".bit_data_idle"}, bit_data_out, 0);
    m = n;
    if (rden_cnt < m) m = rden_cnt;
    if (rdy_cnt / 24 < m) m = rdy_cnt / 24;
    for (int p = 0; p < m; p++) begin
      got = '0;
      for (int i = 0; i < 24; i++) got = {got[22:0], bits_q[p*24 + i]};
      check($sformatf("%s.addr%0d", tag, p), addr_q[p], exp_addr_q[p]);
      check($sformatf("%s.bits%0d", tag, p), got, exp_data_q[p]);
    end
  endtask

  task automatic quiet_check(input string tag);
    int r0, e0;
    r0 = rdy_cnt;
    e0 = rden_cnt;
    repeat (23) begin
      bit_done_in = 1'b1;
      step();
      step();
    end
    check({tag, ".quiet"}, (rdy_cnt - r0) + (rden_cnt - e0), 0);
  endtask

  initial begin
    vecs[0] = '{8'd4,   32'haaaa_cccc, 4,  24'haacccc};
    vecs[1] = '{8'd4,   32'h00aa_dddd, 4,  24'haadddd};
    vecs[2] = '{8'd0,   32'hffff_ffff, 0,  24'h000000};
    vecs[3] = '{8'd200, 32'h1234_5678, 64, 24'h345678};
    vecs[4] = '{8'd1,   32'hff00_0001, 1,  24'h000001};
    vecs[5] = '{8'd65,  32'h0080_0000, 64, 24'h800000};
    vecs[6] = '{8'd63,  32'h00ff_ffff, 63, 24'hffffff};

    rst_in = 1'b1; bit_done_in = 1'b0; wr_done_in = 1'b0; tim_sum_in = 8'd0;
    enc_en = 1'b1;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    clear_logs();

    // Reset state and idle behaviour with stray bit_done pulses.
    repeat (3) step();
    check("reset.outputs", {bit_rdy_out, bit_data_out, rd_en_out, rd_addr_out}, 9'd0);
    rst_in = 1'b0;
    for (int c = 0; c < 20; c++) begin
      bit_done_in = c[0];
      step();
    end
    check("idle.activity", rdy_cnt + rden_cnt, 0);

    // Cycle-exact latency with the encoder held off, then reset mid-frame.
    enc_en = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h0080_0001;
    clear_logs();
    tim_sum_in = 8'd2;
    wr_done_in = 1'b1;
    step();
    check("lat.rd_en_k1", {rd_en_out, rd_addr_out, bit_rdy_out}, {1'b1, 6'd0, 1'b0});
    step();
    check("lat.k2", {rd_en_out, bit_rdy_out}, 2'b00);
    step();
    check("lat.first_bit_k3", {bit_rdy_out, bit_data_out}, 2'b11);
    step();
    check("lat.rdy_width", {bit_rdy_out, bit_data_out}, 2'b01);
    repeat (4) step();
    check("lat.hold_no_done", {bit_rdy_out, bit_data_out, rd_en_out}, 3'b010);
    bit_done_in = 1'b1;
    step();
    check("lat.next_bit_j1", {bit_rdy_out, bit_data_out}, 2'b10);
    wr_done_in = 1'b1;
    step();
    rst_in = 1'b1;
    step();
    check("rst.mid_outputs", {bit_rdy_out, bit_data_out, rd_en_out, rd_addr_out}, 9'd0);
    rst_in = 1'b0;
    clear_logs();
    enc_en = 1'b1;
    for (int c = 0; c < 60; c++) begin
      bit_done_in = (c % 3 == 0);
      step();
    end
    check("rst.aborted", rdy_cnt + rden_cnt, 0);

    // Table of whole frames.
    for (int v = 0; v < 7; v++) begin
      clear_logs();
      for (int i = 0; i < 64; i++) mem[i] = vecs[v].word;
      for (int p = 0; p < vecs[v].exp_pix; p++) begin
        exp_addr_q.push_back(p);
        exp_data_q.push_back(vecs[v].exp_bits);
      end
      tim_sum_in = vecs[v].tim;
      wr_done_in = 1'b1;
      step();
      wait_frame(vecs[v].exp_pix * 24, $sformatf("vec%0d", v));
      check_frame($sformatf("vec%0d", v));
      quiet_check($sformatf("vec%0d", v));
    end

    // Write during a frame: finish it, then replay with a freshly sampled count.
    clear_logs();
    for (int i = 0; i < 64; i++) mem[i] = 32'h0012_3456;
    tim_sum_in = 8'd3;
    wr_done_in = 1'b1;
    step();
    tim_sum_in = 8'd2;
    repeat (50) step();
    wr_done_in = 1'b1;
    wait_frame(5 * 24, "restart");
    exp_addr_q = '{0, 1, 2, 0, 1};
    for (int p = 0; p < 5; p++) exp_data_q.push_back(24'h123456);
    check_frame("restart");
    quiet_check("restart");

    // Distinct word per address, checking addressing and data path per pixel.
    clear_logs();
    for (int i = 0; i < 64; i++)
      mem[i] = 32'hc300_0000 | ((i * 32'h0003_0507) & 32'h00ff_ffff);
    for (int p = 0; p < 8; p++) begin
      exp_addr_q.push_back(p);
      exp_data_q.push_back(24'(p * 24'h030507));
    end
    tim_sum_in = 8'd8;
    wr_done_in = 1'b1;
    step();
    wait_frame(8 * 24, "distinct");
    check_frame("distinct");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
